// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational from the IF-stage PC; updates arrive from EX where
// branches resolve. Also raises mispredict/redirect and keeps branch statistics.
module branch_target_buffer #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned INIT_CTR = 1,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              table_clr,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0]  CtrMax       = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  CtrWeakTaken = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [CTR_W-1:0]  CtrInit      = CTR_W'(INIT_CTR);
  localparam logic [STAT_W-1:0] StatMax      = {STAT_W{1'b1}};

  // Next sequential PC; the top (supervisor) bit never receives a carry.
  function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc);
    logic [ADDR_W-2:0] low;
    low = pc[ADDR_W-2:0] + (ADDR_W-1)'(4);
    return {pc[ADDR_W-1], low};
  endfunction

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [STAT_W-1:0]  branch_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic               lk_hit, up_hit;
  logic [CTR_W-1:0]   ctr_cur, ctr_upd;
  logic               tbl_we, tgt_we;

  // Byte-offset bits of the PCs carry no information for word-aligned fetch.
  logic               unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Lookup reads pre-update contents; no write-to-read bypass.
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : seq_pc(lookup_pc);

  assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign ctr_cur = ctr_q[up_idx];
  // Miss-not-taken leaves the table alone; anything else writes the slot.
  assign tbl_we  = upd_valid && (up_hit || upd_taken);
  assign tgt_we  = upd_valid && upd_taken;

  assign mispredict  = upd_valid &&
                       ((upd_pred_taken != upd_taken) ||
                        (upd_taken && (upd_pred_target != upd_target)));
  assign redirect_pc = upd_taken ? upd_target : seq_pc(upd_pc);

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  // Next counter value for the slot being updated: saturating step on a hit,
  // weakly-taken on allocation.
  always_comb begin
    ctr_upd = ctr_cur;
    if (up_hit) begin
      if (upd_taken) begin
        ctr_upd = (ctr_cur == CtrMax) ? ctr_cur : ctr_cur + CTR_W'(1);
      end else begin
        ctr_upd = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_W'(1);
      end
    end else begin
      ctr_upd = CtrWeakTaken;
    end
  end

  // Valid bits and counters; clear wins over a coincident update.
  always_ff @(posedge clk) begin
    if (reset || table_clr) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CtrInit;
      end
    end else if (tbl_we) begin
      valid_q[up_idx] <= 1'b1;
      ctr_q[up_idx]   <= ctr_upd;
    end
  end

  // Tag and target storage, left unreset since it is masked by valid.
  always_ff @(posedge clk) begin
    if (!reset && !table_clr && tgt_we) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target;
    end
  end

  // Saturating statistics; clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (upd_valid && (branch_cnt_q != StatMax)) begin
        branch_cnt_q <= branch_cnt_q + STAT_W'(1);
      end
      if (mispredict && (miss_cnt_q != StatMax)) begin
        miss_cnt_q <= miss_cnt_q + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: vector records are driven just
// after a rising edge, pushed to a scoreboard, and checked at the falling edge.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        table_clr;
  logic        stat_clr;
  logic [3:0]  branch_cnt;
  logic [3:0]  miss_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(
    .ENTRIES (16),
    .ADDR_W  (32),
    .CTR_W   (2),
    .INIT_CTR(1),
    .STAT_W  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .lookup_pc      (lookup_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .table_clr      (table_clr),
    .stat_clr       (stat_clr),
    .branch_cnt     (branch_cnt),
    .miss_cnt       (miss_cnt)
  );

  // ctl = {reset, stat_clr, table_clr, upd_valid, upd_taken, upd_pred_taken}
  // ef  = {expected pred_taken, expected mispredict}
  // e_bc/e_mc are the counter values visible during the cycle (before its edge).
  typedef struct {
    logic [63:0] nm;
    logic [31:0] lpc;
    logic [5:0]  ctl;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic [31:0] uptgt;
    logic [1:0]  ef;
    logic [31:0] e_ptgt;
    logic [31:0] e_redir;
    logic [3:0]  e_bc;
    logic [3:0]  e_mc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic [63:0] nm, input logic [31:0] lpc,
                              input logic [5:0] ctl, input logic [31:0] upc,
                              input logic [31:0] utgt, input logic [31:0] uptgt,
                              input logic [1:0] ef, input logic [31:0] e_ptgt,
                              input logic [31:0] e_redir, input logic [3:0] e_bc,
                              input logic [3:0] e_mc);
    vec_t v;
    v.nm = nm; v.lpc = lpc; v.ctl = ctl; v.upc = upc; v.utgt = utgt;
    v.uptgt = uptgt; v.ef = ef; v.e_ptgt = e_ptgt; v.e_redir = e_redir;
    v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic chk(input logic [63:0] nm, input logic [63:0] fld,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %0s.%0s: got %h expected %h at %0t", nm, fld, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    {reset, stat_clr, table_clr, upd_valid, upd_taken, upd_pred_taken} = v.ctl;
    lookup_pc       = v.lpc;
    upd_pc          = v.upc;
    upd_target      = v.utgt;
    upd_pred_target = v.uptgt;
    sb.push_back(v);
  endtask

  // Scoreboard checker: pop the expectation for the cycle driven at the last edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      vec_t e;
      e = sb.pop_front();
      chk(e.nm, "pt",   32'(pred_taken),  32'(e.ef[1]));
      chk(e.nm, "ptgt", pred_target,      e.e_ptgt);
      chk(e.nm, "mis",  32'(mispredict),  32'(e.ef[0]));
      if (e.ef[0]) chk(e.nm, "redir", redirect_pc, e.e_redir);
      chk(e.nm, "bcnt", 32'(branch_cnt),  32'(e.e_bc));
      chk(e.nm, "mcnt", 32'(miss_cnt),    32'(e.e_mc));
    end
  end

  initial begin
    // Reset sequence and the table-driven vectors.
    //               name        lookup        ctl        upd_pc        upd_tgt      pred_tgt     ef     e_ptgt        e_redir    bc  mc
    vecs.push_back(mk("rst_lk40", 32'h40,       6'b000000, 32'h0,    32'h0,    32'h0,    2'b00, 32'h44,       32'h0,   4'd0, 4'd0));
    vecs.push_back(mk("seq_b31",  32'h80000FFC, 6'b000000, 32'h0,    32'h0,    32'h0,    2'b00, 32'h80001000, 32'h0,   4'd0, 4'd0));
    vecs.push_back(mk("nocarry",  32'hFFFFFFFC, 6'b000000, 32'h0,    32'h0,    32'h0,    2'b00, 32'h80000000, 32'h0,   4'd0, 4'd0));
    vecs.push_back(mk("alloc40",  32'h40,       6'b000110, 32'h40,   32'h100,  32'h44,   2'b01, 32'h44,       32'h100, 4'd0, 4'd0));
    vecs.push_back(mk("tk1",      32'h40,       6'b000111, 32'h40,   32'h100,  32'h100,  2'b10, 32'h100,      32'h0,   4'd1, 4'd1));
    vecs.push_back(mk("tk2",      32'h40,       6'b000111, 32'h40,   32'h100,  32'h100,  2'b10, 32'h100,      32'h0,   4'd2, 4'd1));
    vecs.push_back(mk("tk3",      32'h40,       6'b000111, 32'h40,   32'h100,  32'h100,  2'b10, 32'h100,      32'h0,   4'd3, 4'd1));
    vecs.push_back(mk("nt1",      32'h40,       6'b000101, 32'h40,   32'h100,  32'h100,  2'b11, 32'h100,      32'h44,  4'd4, 4'd1));
    vecs.push_back(mk("nt2",      32'h40,       6'b000101, 32'h40,   32'h100,  32'h100,  2'b11, 32'h100,      32'h44,  4'd5, 4'd2));
    vecs.push_back(mk("lk_nt",    32'h40,       6'b000000, 32'h0,    32'h0,    32'h0,    2'b00, 32'h44,       32'h0,   4'd6, 4'd3));
    vecs.push_back(mk("tgtmis",   32'h200,      6'b000111, 32'h40,   32'h180,  32'h100,  2'b01, 32'h204,      32'h180, 4'd6, 4'd3));
    vecs.push_back(mk("lk180",    32'h40,       6'b000000, 32'h0,    32'h0,    32'h0,    2'b10, 32'h180,      32'h0,   4'd7, 4'd4));
    vecs.push_back(mk("alloc80",  32'h80,       6'b000110, 32'h80,   32'h300,  32'h84,   2'b01, 32'h84,       32'h300, 4'd7, 4'd4));
    vecs.push_back(mk("evicted",  32'h40,       6'b000000, 32'h0,    32'h0,    32'h0,    2'b00, 32'h44,       32'h0,   4'd8, 4'd5));
    vecs.push_back(mk("lk80",     32'h80,       6'b000000, 32'h0,    32'h0,    32'h0,    2'b10, 32'h300,      32'h0,   4'd8, 4'd5));
    vecs.push_back(mk("miss_nt",  32'h80,       6'b000100, 32'h44,   32'h0,    32'h48,   2'b10, 32'h300,      32'h0,   4'd8, 4'd5));
    vecs.push_back(mk("noalloc",  32'h44,       6'b000000, 32'h0,    32'h0,    32'h0,    2'b00, 32'h48,       32'h0,   4'd9, 4'd5));
    vecs.push_back(mk("clr_upd",  32'h80,       6'b001110, 32'h48,   32'h500,  32'h4C,   2'b11, 32'h300,      32'h500, 4'd9, 4'd5));
    vecs.push_back(mk("clr_80",   32'h80,       6'b000000, 32'h0,    32'h0,    32'h0,    2'b00, 32'h84,       32'h0,   4'd10, 4'd6));
    vecs.push_back(mk("clr_48",   32'h48,       6'b000000, 32'h0,    32'h0,    32'h0,    2'b00, 32'h4C,       32'h0,   4'd10, 4'd6));
    vecs.push_back(mk("uv0",      32'h48,       6'b000010, 32'h48,   32'h500,  32'h4C,   2'b00, 32'h4C,       32'h0,   4'd10, 4'd6));
    vecs.push_back(mk("uv0_cnt",  32'h0,        6'b000000, 32'h0,    32'h0,    32'h0,    2'b00, 32'h4,        32'h0,   4'd10, 4'd6));

    reset = 1'b1; stat_clr = 1'b0; table_clr = 1'b0; upd_valid = 1'b0;
    upd_taken = 1'b0; upd_pred_taken = 1'b0; lookup_pc = '0; upd_pc = '0;
    upd_target = '0; upd_pred_target = '0;
    repeat (3) @(posedge clk);

    foreach (vecs[i]) drive(vecs[i]);

    // Saturation: clear stats, then 17 mispredicts; both counters stick at 15.
    drive(mk("sclr", 32'h0, 6'b010000, 32'h0, 32'h0, 32'h0, 2'b00, 32'h4, 32'h0, 4'd10, 4'd6));
    for (int i = 0; i < 17; i++) begin
      logic [3:0] c;
      c = (i > 15) ? 4'd15 : 4'(i);
      drive(mk("satmis", 32'h0, 6'b000110, 32'h1000, 32'h2000, 32'h1004, 2'b01, 32'h4,
               32'h2000, c, c));
    end
    // stat_clr wins over a coincident mispredict.
    drive(mk("sclrmis", 32'h0, 6'b010110, 32'h1000, 32'h2000, 32'h1004, 2'b01, 32'h4,
             32'h2000, 4'd15, 4'd15));
    drive(mk("sclrchk", 32'h0, 6'b000000, 32'h0, 32'h0, 32'h0, 2'b00, 32'h4, 32'h0, 4'd0, 4'd0));

    // Reset with an update pending: the update is discarded and the table empties.
    drive(mk("rstupd", 32'h1000, 6'b100110, 32'h1000, 32'h2000, 32'h1004, 2'b11, 32'h2000,
             32'h2000, 4'd0, 4'd0));
    drive(mk("postrst", 32'h1000, 6'b000000, 32'h0, 32'h0, 32'h0, 2'b00, 32'h1004, 32'h0,
             4'd0, 4'd0));

    for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
